// File: rtl/sys_tile_addr_gen.sv
// sys_tile_addr_gen
//   Streams one TILE x TILE tile of addresses per request on three independent
//   channels: A operand (ROW_M x COL_M), W operand (COL_M x COL_N) and result C
//   (ROW_M x COL_N). Beats outside the matrix on edge tiles are flagged as pad
//   beats (address 0) so the consumer can inject zeros.
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   tile_i/tile_j/tile_k       tile indices, sampled on a channel start
//   w_transpose                W walk order (1 = column-major), sampled on start_w
//   start_a/start_w/start_c    per-channel request pulse
//   ready_a/ready_w/ready_c    consumer accepts the current beat
//   addr_a/addr_w/addr_res     registered beat address
//   valid_*/pad_*/busy_*       beat valid, beat is padding, channel mid-burst
//   done_*                     one-cycle pulse after the last handshake
//   err                        one-cycle pulse after an out-of-range start
//
// Addresses are computed in 32 bits and truncated, so ADDR_WIDTH <= 32.

module sys_tile_addr_gen #(
  parameter int unsigned ROW_M      = 5,
  parameter int unsigned COL_M      = 4,
  parameter int unsigned COL_N      = 6,
  parameter int unsigned TILE       = 2,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned A_ADDR     = 32'h000,
  parameter int unsigned W_ADDR     = 32'h100,
  parameter int unsigned C_ADDR     = 32'h200,
  localparam int unsigned TM   = (ROW_M + TILE - 1) / TILE,
  localparam int unsigned TK   = (COL_M + TILE - 1) / TILE,
  localparam int unsigned TN   = (COL_N + TILE - 1) / TILE,
  localparam int unsigned TMAX = (TM > TK) ? ((TM > TN) ? TM : TN) : ((TK > TN) ? TK : TN),
  localparam int unsigned TW   = $clog2(TMAX) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [TW-1:0]         tile_i,
  input  logic [TW-1:0]         tile_j,
  input  logic [TW-1:0]         tile_k,
  input  logic                  w_transpose,
  input  logic                  start_a,
  input  logic                  start_w,
  input  logic                  start_c,
  input  logic                  ready_a,
  input  logic                  ready_w,
  input  logic                  ready_c,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [ADDR_WIDTH-1:0] addr_res,
  output logic                  valid_a,
  output logic                  valid_w,
  output logic                  valid_c,
  output logic                  pad_a,
  output logic                  pad_w,
  output logic                  pad_c,
  output logic                  busy_a,
  output logic                  busy_w,
  output logic                  busy_c,
  output logic                  done_a,
  output logic                  done_w,
  output logic                  done_c,
  output logic                  err
);

  localparam int unsigned   CW   = $clog2(TILE);
  localparam logic [CW-1:0] LAST = CW'(TILE - 1);

  // Channel index: 0 = A, 1 = W, 2 = C.
  logic [2:0] w_start;
  logic [2:0] w_ready;
  logic [2:0] w_in_range;
  logic [31:0] w_row0_in [3];
  logic [31:0] w_col0_in [3];

  assign w_start = {start_c, start_w, start_a};
  assign w_ready = {ready_c, ready_w, ready_a};
  assign w_in_range = {
    (32'(tile_i) < TM) && (32'(tile_j) < TN),
    (32'(tile_k) < TK) && (32'(tile_j) < TN),
    (32'(tile_i) < TM) && (32'(tile_k) < TK)
  };

  always_comb begin
    w_row0_in[0] = 32'(tile_i) * TILE;
    w_col0_in[0] = 32'(tile_k) * TILE;
    w_row0_in[1] = 32'(tile_k) * TILE;
    w_col0_in[1] = 32'(tile_j) * TILE;
    w_row0_in[2] = 32'(tile_i) * TILE;
    w_col0_in[2] = 32'(tile_j) * TILE;
  end

  wire [2:0]            w_run;
  wire [2:0]            w_pad;
  wire [2:0]            w_done;
  wire [2:0]            w_rej;
  wire [ADDR_WIDTH-1:0] w_addr [3];

  for (genvar g = 0; g < 3; g++) begin : g_chan
    localparam int unsigned ROWS = (g == 1) ? COL_M : ROW_M;
    localparam int unsigned COLS = (g == 0) ? COL_M : COL_N;
    localparam int unsigned BASE = (g == 0) ? A_ADDR : ((g == 1) ? W_ADDR : C_ADDR);

    logic                  r_run;
    logic                  r_done;
    logic                  r_pad;
    logic                  r_trans;
    logic [CW-1:0]         r_r;
    logic [CW-1:0]         r_c;
    logic [31:0]           r_row0;
    logic [31:0]           r_col0;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_run_d;
    logic                  w_done_d;
    logic                  w_pad_d;
    logic                  w_trans_d;
    logic                  w_rej_d;
    logic                  w_last;
    logic [CW-1:0]         w_r_d;
    logic [CW-1:0]         w_c_d;
    logic [31:0]           w_row0_d;
    logic [31:0]           w_col0_d;
    logic [31:0]           w_row;
    logic [31:0]           w_col;
    logic [31:0]           w_full;
    logic [ADDR_WIDTH-1:0] w_addr_d;

    always_comb begin
      w_run_d   = r_run;
      w_done_d  = 1'b0;
      w_trans_d = r_trans;
      w_rej_d   = 1'b0;
      w_r_d     = r_r;
      w_c_d     = r_c;
      w_row0_d  = r_row0;
      w_col0_d  = r_col0;
      w_last    = (r_r == LAST) && (r_c == LAST);

      if (!r_run) begin
        if (w_start[g]) begin
          if (w_in_range[g]) begin
            w_run_d   = 1'b1;
            w_r_d     = '0;
            w_c_d     = '0;
            w_row0_d  = w_row0_in[g];
            w_col0_d  = w_col0_in[g];
            w_trans_d = (g == 1) ? w_transpose : 1'b0;
          end else begin
            w_rej_d = 1'b1;
          end
        end
      end else if (w_ready[g]) begin
        if (w_last) begin
          w_run_d  = 1'b0;
          w_done_d = 1'b1;
          w_r_d    = '0;
          w_c_d    = '0;
        end else if (r_trans) begin
          // Column-major: r is the inner counter.
          if (r_r == LAST) begin
            w_r_d = '0;
            w_c_d = r_c + CW'(1);
          end else begin
            w_r_d = r_r + CW'(1);
          end
        end else begin
          if (r_c == LAST) begin
            w_c_d = '0;
            w_r_d = r_r + CW'(1);
          end else begin
            w_c_d = r_c + CW'(1);
          end
        end
      end

      // The next beat's address is computed ahead so the outputs are registered.
      w_row    = w_row0_d + 32'(w_r_d);
      w_col    = w_col0_d + 32'(w_c_d);
      w_full   = BASE + w_row * COLS + w_col;
      w_pad_d  = w_run_d && ((w_row >= ROWS) || (w_col >= COLS));
      w_addr_d = (w_run_d && !w_pad_d) ? ADDR_WIDTH'(w_full) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_run   <= 1'b0;
        r_done  <= 1'b0;
        r_pad   <= 1'b0;
        r_trans <= 1'b0;
        r_r     <= '0;
        r_c     <= '0;
        r_row0  <= '0;
        r_col0  <= '0;
        r_addr  <= '0;
      end else begin
        r_run   <= w_run_d;
        r_done  <= w_done_d;
        r_pad   <= w_pad_d;
        r_trans <= w_trans_d;
        r_r     <= w_r_d;
        r_c     <= w_c_d;
        r_row0  <= w_row0_d;
        r_col0  <= w_col0_d;
        r_addr  <= w_addr_d;
      end
    end

    assign w_run[g]  = r_run;
    assign w_pad[g]  = r_pad;
    assign w_done[g] = r_done;
    assign w_rej[g]  = w_rej_d;
    assign w_addr[g] = r_addr;
  end

  logic r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= |w_rej;
    end
  end

  assign addr_a   = w_addr[0];
  assign addr_w   = w_addr[1];
  assign addr_res = w_addr[2];
  assign valid_a  = w_run[0];
  assign valid_w  = w_run[1];
  assign valid_c  = w_run[2];
  assign busy_a   = w_run[0];
  assign busy_w   = w_run[1];
  assign busy_c   = w_run[2];
  assign pad_a    = w_pad[0];
  assign pad_w    = w_pad[1];
  assign pad_c    = w_pad[2];
  assign done_a   = w_done[0];
  assign done_w   = w_done[1];
  assign done_c   = w_done[2];
  assign err      = r_err;

endmodule

// File: tb/tb_sys_tile_addr_gen.sv
module tb_sys_tile_addr_gen;

  localparam int ROW_M = 5;
  localparam int COL_M = 4;
  localparam int COL_N = 6;
  localparam int TILE  = 2;
  localparam int AW    = 12;
  localparam int TM    = 3;
  localparam int TK    = 2;
  localparam int TN    = 3;
  localparam int TW    = 3;
  localparam int T2    = TILE * TILE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [TW-1:0] tile_i = '0;
  logic [TW-1:0] tile_j = '0;
  logic [TW-1:0] tile_k = '0;
  logic          w_transpose = 1'b0;
  logic          start_a = 1'b0, start_w = 1'b0, start_c = 1'b0;
  logic          ready_a = 1'b0, ready_w = 1'b0, ready_c = 1'b0;
  logic [AW-1:0] addr_a, addr_w, addr_res;
  logic          valid_a, valid_w, valid_c;
  logic          pad_a, pad_w, pad_c;
  logic          busy_a, busy_w, busy_c;
  logic          done_a, done_w, done_c;
  logic          err;

  int total = 0;
  int bad   = 0;

  sys_tile_addr_gen dut (
    .clk         (clk),
    .reset       (reset),
    .tile_i      (tile_i),
    .tile_j      (tile_j),
    .tile_k      (tile_k),
    .w_transpose (w_transpose),
    .start_a     (start_a),
    .start_w     (start_w),
    .start_c     (start_c),
    .ready_a     (ready_a),
    .ready_w     (ready_w),
    .ready_c     (ready_c),
    .addr_a      (addr_a),
    .addr_w      (addr_w),
    .addr_res    (addr_res),
    .valid_a     (valid_a),
    .valid_w     (valid_w),
    .valid_c     (valid_c),
    .pad_a       (pad_a),
    .pad_w       (pad_w),
    .pad_c       (pad_c),
    .busy_a      (busy_a),
    .busy_w      (busy_w),
    .busy_c      (busy_c),
    .done_a      (done_a),
    .done_w      (done_w),
    .done_c      (done_c),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Reference: beat b of a channel's tile, straight from the matrix geometry.
  function automatic void model_beat(input int ch, input int ti, input int tj, input int tk,
                                     input bit tr, input int b,
                                     output logic [AW-1:0] ea, output logic ep);
    int rows, cols, base, row0, col0, r, c, row, col;
    case (ch)
      0: begin rows = ROW_M; cols = COL_M; base = 'h000; row0 = ti * TILE; col0 = tk * TILE; end
      1: begin rows = COL_M; cols = COL_N; base = 'h100; row0 = tk * TILE; col0 = tj * TILE; end
      default: begin
        rows = ROW_M; cols = COL_N; base = 'h200; row0 = ti * TILE; col0 = tj * TILE;
      end
    endcase
    if (ch == 1 && tr) begin
      r = b % TILE; c = b / TILE;
    end else begin
      r = b / TILE; c = b % TILE;
    end
    row = row0 + r;
    col = col0 + c;
    ep  = (row >= rows) || (col >= cols);
    ea  = ep ? '0 : AW'((base + row * cols + col) % (1 << AW));
  endfunction

  task automatic peek(input int ch, output logic v, output logic p, output logic bz,
                      output logic d, output logic [AW-1:0] a);
    case (ch)
      0: begin v = valid_a; p = pad_a; bz = busy_a; d = done_a; a = addr_a; end
      1: begin v = valid_w; p = pad_w; bz = busy_w; d = done_w; a = addr_w; end
      default: begin v = valid_c; p = pad_c; bz = busy_c; d = done_c; a = addr_res; end
    endcase
  endtask

  task automatic set_start(input int ch, input logic on);
    case (ch)
      0: start_a = on;
      1: start_w = on;
      default: start_c = on;
    endcase
  endtask

  task automatic set_ready(input int ch, input logic on);
    case (ch)
      0: ready_a = on;
      1: ready_w = on;
      default: ready_c = on;
    endcase
  endtask

  function automatic logic [3*AW+15:0] all_outs();
    return {addr_a, addr_w, addr_res, valid_a, valid_w, valid_c, pad_a, pad_w, pad_c,
            busy_a, busy_w, busy_c, done_a, done_w, done_c, err};
  endfunction

  // mode 0: always ready, 1: random ready, 2: ready from pattern bit per cycle.
  // A start of the same channel (different indices) is injected at cycle inject_at.
  task automatic run_burst(input int ch, input int ti, input int tj, input int tk, input bit tr,
                           input int mode, input logic [31:0] pattern, input int inject_at);
    logic v, p, bz, d, ep;
    logic [AW-1:0] a, ea;
    logic rdy;
    int b = 0;
    int cyc = 0;
    @(negedge clk);
    tile_i = TW'(ti); tile_j = TW'(tj); tile_k = TW'(tk); w_transpose = tr;
    set_start(ch, 1'b1);
    @(negedge clk);
    set_start(ch, 1'b0);
    while (b < T2 && cyc < 200) begin
      peek(ch, v, p, bz, d, a);
      model_beat(ch, ti, tj, tk, tr, b, ea, ep);
      total++;
      if (v !== 1'b1 || bz !== 1'b1 || a !== ea || p !== ep || err !== 1'b0 || d !== 1'b0) begin
        bad++;
        $display("FAIL beat ch%0d tile(%0d,%0d,%0d) tr=%0d beat=%0d cyc=%0d: got v=%b busy=%b addr=%h pad=%b done=%b err=%b, want v=1 busy=1 addr=%h pad=%b done=0 err=0",
                 ch, ti, tj, tk, tr, b, cyc, v, bz, a, p, d, err, ea, ep);
      end
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = pattern[cyc % 32];
      endcase
      set_ready(ch, rdy);
      if (cyc == inject_at) begin
        tile_i = '0; tile_j = '0; tile_k = '0; w_transpose = ~tr;
        set_start(ch, 1'b1);
      end
      @(negedge clk);
      set_start(ch, 1'b0);
      if (rdy) b++;
      cyc++;
    end
    set_ready(ch, 1'b0);
    total++;
    if (b < T2) begin
      bad++;
      $display("FAIL burst_timeout ch%0d: got %0d beats, want %0d", ch, b, T2);
    end
    peek(ch, v, p, bz, d, a);
    total++;
    if (v !== 1'b0 || bz !== 1'b0 || d !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse ch%0d: got v=%b busy=%b done=%b err=%b, want v=0 busy=0 done=1 err=0",
               ch, v, bz, d, err);
    end
    @(negedge clk);
    peek(ch, v, p, bz, d, a);
    total++;
    if (v !== 1'b0 || bz !== 1'b0 || d !== 1'b0 || p !== 1'b0 || err !== 1'b0) begin
      bad++;
      $display("FAIL after_done ch%0d: got v=%b busy=%b done=%b pad=%b err=%b, want all 0",
               ch, v, bz, d, p, err);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #1;
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_async: got %h, want 0", all_outs());
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (all_outs() !== '0) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got %h, want 0", n, all_outs());
      end
    end
  endtask

  task automatic test_reset_midburst();
    @(negedge clk);
    tile_i = 3'd1; tile_k = 3'd1; start_a = 1'b1; ready_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: got %h, want 0", all_outs());
    end
    @(negedge clk);
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_mid_hold: got %h, want 0", all_outs());
    end
    ready_a = 1'b0;
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (all_outs() !== '0) begin
        bad++;
        $display("FAIL reset_mid_release cyc%0d: got %h, want 0", n, all_outs());
      end
    end
  endtask

  task automatic test_directed();
    run_burst(0, 1, 0, 1, 1'b0, 0, 32'h0, -1);   // A interior: 10,11,14,15
    run_burst(0, 2, 0, 0, 1'b0, 0, 32'h0, -1);   // A edge: 16,17 then two pads
    run_burst(1, 0, 2, 0, 1'b1, 0, 32'h0, -1);   // W transposed
    run_burst(1, 0, 2, 0, 1'b0, 0, 32'h0, -1);   // W row-major
    run_burst(1, 0, 2, 1, 1'b1, 0, 32'h0, -1);
    run_burst(2, 2, 2, 0, 1'b0, 0, 32'h0, -1);   // C corner tile: row 5 pads
  endtask

  task automatic test_backpressure();
    // Ready low on the 2nd and 3rd presented cycles: 0x201 holds for 3 cycles.
    run_burst(2, 0, 0, 0, 1'b0, 2, 32'hFFFF_FFF9, -1);
  endtask

  task automatic test_busy_start();
    run_burst(0, 1, 0, 1, 1'b0, 0, 32'h0, 1);    // start mid-burst
    run_burst(0, 1, 0, 1, 1'b0, 0, 32'h0, T2 - 1); // start on the final-beat cycle
  endtask

  task automatic test_reject();
    int chs [3] = '{2, 0, 1};
    int tis [3] = '{0, 3, 0};
    int tjs [3] = '{3, 0, 0};
    int tks [3] = '{0, 0, 2};
    logic v, p, bz, d;
    logic [AW-1:0] a;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      tile_i = TW'(tis[n]); tile_j = TW'(tjs[n]); tile_k = TW'(tks[n]);
      set_start(chs[n], 1'b1);
      @(negedge clk);
      set_start(chs[n], 1'b0);
      peek(chs[n], v, p, bz, d, a);
      total++;
      if (err !== 1'b1 || bz !== 1'b0 || v !== 1'b0) begin
        bad++;
        $display("FAIL reject ch%0d: got err=%b busy=%b valid=%b, want err=1 busy=0 valid=0",
                 chs[n], err, bz, v);
      end
      @(negedge clk);
      peek(chs[n], v, p, bz, d, a);
      total++;
      if (err !== 1'b0 || bz !== 1'b0) begin
        bad++;
        $display("FAIL reject_pulse ch%0d: got err=%b busy=%b, want err=0 busy=0",
                 chs[n], err, bz);
      end
    end
  endtask

  task automatic test_all_channels();
    logic v, p, bz, d, ep;
    logic [AW-1:0] a, ea;
    @(negedge clk);
    tile_i = 3'd1; tile_j = 3'd1; tile_k = 3'd0; w_transpose = 1'b1;
    start_a = 1'b1; start_w = 1'b1; start_c = 1'b1;
    ready_a = 1'b1; ready_w = 1'b1; ready_c = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_w = 1'b0; start_c = 1'b0;
    for (int b = 0; b < T2; b++) begin
      for (int ch = 0; ch < 3; ch++) begin
        peek(ch, v, p, bz, d, a);
        model_beat(ch, 1, 1, 0, 1'b1, b, ea, ep);
        total++;
        if (v !== 1'b1 || a !== ea || p !== ep) begin
          bad++;
          $display("FAIL all_chan ch%0d beat%0d: got v=%b addr=%h pad=%b, want v=1 addr=%h pad=%b",
                   ch, b, v, a, p, ea, ep);
        end
      end
      @(negedge clk);
    end
    for (int ch = 0; ch < 3; ch++) begin
      peek(ch, v, p, bz, d, a);
      total++;
      if (d !== 1'b1 || bz !== 1'b0) begin
        bad++;
        $display("FAIL all_chan_done ch%0d: got done=%b busy=%b, want done=1 busy=0", ch, d, bz);
      end
    end
    ready_a = 1'b0; ready_w = 1'b0; ready_c = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int ch, ti, tj, tk;
    bit tr;
    for (int n = 0; n < 24; n++) begin
      ch = int'($urandom_range(0, 2));
      ti = int'($urandom_range(0, TM - 1));
      tj = int'($urandom_range(0, TN - 1));
      tk = int'($urandom_range(0, TK - 1));
      tr = 1'($urandom_range(0, 1));
      run_burst(ch, ti, tj, tk, tr, 1, 32'h0, -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_busy_start();
    test_reject();
    test_all_channels();
    test_random();
    test_reset_midburst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sys_tile_addr_gen.md
# sys_tile_addr_gen

Parametrised address generator for the tiled systolic array. It streams one TILE×TILE tile of addresses per request on three independent channels: A operand (M×K), W operand (K×N) and result C (M×N). Each channel has ready/valid backpressure and flags padding beats on edge tiles whose dimensions are not a multiple of TILE. It sits between the tile scheduler, which issues tile indices and start pulses, and the shared memory port.

## Interface
- ROW_M, 5, rows of A and C
- COL_M, 4, columns of A and rows of W (K)
- COL_N, 6, columns of W and C
- TILE, 2, tile edge length; power of two, ≥2
- ADDR_WIDTH, 12, address width
- A_ADDR / W_ADDR / C_ADDR, 0x000 / 0x100 / 0x200, base addresses of the row-major matrices
- Derived: TM=ceil(ROW_M/TILE), TK=ceil(COL_M/TILE), TN=ceil(COL_N/TILE); TW=$clog2(max(TM,TK,TN))+1

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- tile_i / tile_j / tile_k  in  TW each  tile indices, sampled on start
- w_transpose  in  1  W walk order, sampled on start_w
- start_a / start_w / start_c  in  1  request pulse per channel
- ready_a / ready_w / ready_c  in  1  consumer accepts the current beat
- addr_a / addr_w / addr_res  out  ADDR_WIDTH  current beat address
- valid_a / valid_w / valid_c  out  1  beat valid
- pad_a / pad_w / pad_c  out  1  beat lies outside the matrix; consumer injects zero
- busy_a / busy_w / busy_c  out  1  channel mid-burst
- done_a / done_w / done_c  out  1  one-cycle pulse after the last beat
- err  out  1  one-cycle pulse on a rejected start

## Operation
- Three identical channel engines. Each engine has an IDLE/RUN state machine and tile-local counters r, c, each $clog2(TILE) bits.
- Origin on start: A row0=tile_i·TILE, col0=tile_k·TILE, stride COL_M. W row0=tile_k·TILE, col0=tile_j·TILE, stride COL_N. C row0=tile_i·TILE, col0=tile_j·TILE, stride COL_N.
- Beat address = BASE + (row0+r)·stride + (col0+c). Computed at full precision, then truncated modulo 2^ADDR_WIDTH.
- Walk order: row-major (c inner, r outer) for A, C, and W when w_transpose=0. Column-major (r inner) for W when w_transpose=1.
- Pad beats:
  - A beat is a pad beat when row0+r ≥ rows or col0+c ≥ cols.
  - On a pad beat: pad=1, address=0, valid=1. The beat still consumes a handshake.
  - Every burst is exactly TILE² beats.
- IDLE→RUN: start=1 while idle and tile indices in range (A: i<TM, k<TK; W: k<TK, j<TN; C: i<TM, j<TN). Counters clear to 0; origin and mode latch.
- Out-of-range start: ignored; err pulses the next cycle.
- start while busy (including the final-beat cycle): ignored silently; no err.
- RUN: the counters advance only on valid&&ready. The address, pad flag and counters hold while ready=0.
- RUN→IDLE: on handshake of beat TILE²−1.
- Channels are fully independent. Simultaneous starts on all three are all accepted.
- Reset, including mid-burst: all state returns to IDLE immediately; the burst is abandoned with no done pulse.

## Timing
- Reset values: all valid/pad/busy/done/err = 0; addr_a/addr_w/addr_res = 0; counters and origins = 0.
- Start sampled at edge t → busy=1 and valid=1 with beat 0 registered at t+1. Latency is 1 cycle.
- Handshake at edge x → next beat presented at x+1. Full throughput is 1 beat per cycle.
- Final handshake at edge x → at x+1: valid=0, busy=0, done=1 for one cycle. A start sampled at x+1 presents beat 0 at x+2.
- All outputs are registered; no combinational path from ready to addr.

## Test plan
- Reset: drive reset=0 mid-stream → all outputs 0 within the same cycle, held until release. After release, with start_* held 0: outputs stay 0 and busy stays 0.
- A interior tile: tile_i=1, tile_k=1, ready_a=1 → addr_a 10,11,14,15 on consecutive cycles with pad_a=0. done_a pulses the cycle after 15.
- A edge tile: tile_i=2, tile_k=0 (rows 4–5, only row 4 exists) → addr 16,17 with pad=0, then 0,0 with pad=1. done_a follows.
- W transpose: tile_k=0, tile_j=2, w_transpose=1 → addr_w 0x104, 0x10A, 0x105, 0x10B. Repeat with w_transpose=0 → 0x104, 0x105, 0x10A, 0x10B.
- C backpressure: tile_i=0, tile_j=0, with ready_c low on cycles 2–3 → addr_res holds 0x201 for 3 cycles. Accepted sequence is 0x200, 0x201, 0x206, 0x207.
- Rejects:
  - start_c with tile_j=3 (TN=3) → err pulse 1 cycle later; busy_c stays 0.
  - start_a while busy_a → burst continues unchanged; no err.
  - start_a on the final-beat cycle → ignored.
